// File: rtl/gate_mac_if.sv
// Term/result handshake bundle for gate_mac: a term stream in, a result stream out.
interface gate_mac_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_w;
   logic [DATA_WIDTH-1:0] in_x;
   logic [DATA_WIDTH-1:0] in_b;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [CNT_WIDTH-1:0]  term_cnt;

   modport master (
      output in_valid, in_w, in_x, in_b, out_ready,
      input  in_ready, out_valid, out_data, term_cnt
   );

   modport slave (
      input  in_valid, in_w, in_x, in_b, out_ready,
      output in_ready, out_valid, out_data, term_cnt
   );
endinterface

// File: rtl/gate_mac.sv
// Fixed-point gate MAC: out = sum(W*X) + b over N_TERMS accepted terms.
// Define GATE_MAC_SAT_EN to saturate the result instead of wrapping it.
module gate_mac #(
   parameter int DATA_WIDTH  = 16,
   parameter int FRACT_WIDTH = 8,
   parameter int N_TERMS     = 4,
   parameter int ACC_WIDTH   = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   gate_mac_if.slave  bus
);
   localparam int CNT_W  = $clog2(N_TERMS + 1);
   localparam int PROD_W = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e                        state_q, state_d;
   logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
   logic                          out_valid_q, out_valid_d;
   logic                          in_ready_s;
   logic                          accept_s;
   logic signed [PROD_W-1:0]      prod_full_s;
   logic signed [PROD_W-1:0]      prod_shift_s;
   logic signed [ACC_WIDTH-1:0]   prod_ext_s;
   logic signed [ACC_WIDTH-1:0]   bias_ext_s;
   logic [DATA_WIDTH-1:0]         out_conv_s;

   assign accept_s     = bus.in_valid && in_ready_s;
   assign prod_full_s  = PROD_W'($signed(bus.in_w)) * PROD_W'($signed(bus.in_x));
   // Arithmetic shift floors toward minus infinity, matching the fixed-point rule.
   assign prod_shift_s = prod_full_s >>> FRACT_WIDTH;
   assign prod_ext_s   = ACC_WIDTH'(prod_shift_s);
   assign bias_ext_s   = ACC_WIDTH'($signed(bus.in_b));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; clr overrides every handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = (N_TERMS == 1) ? DONE : ACCUM;
            end else begin
               state_d = IDLE;
            end
         end
         ACCUM: begin
            if (accept_s && (cnt_q == CNT_W'(N_TERMS - 1))) begin
               state_d = DONE;
            end else begin
               state_d = ACCUM;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (clr) begin
         state_d = IDLE;
      end else begin
         state_d = state_d;
      end
   end

   // FSM outputs: ready decoded from current state, valid registered from next state.
   always_comb begin
      in_ready_s  = (state_q != DONE);
      out_valid_d = (state_d == DONE);
   end

   // Accumulator and term counter update.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (accept_s) begin
         if (state_q == IDLE) begin
            acc_d = bias_ext_s + prod_ext_s;
            cnt_d = CNT_W'(1);
         end else begin
            acc_d = acc_q + prod_ext_s;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if ((state_q == DONE) && bus.out_ready) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Narrow the accumulator to the output format.
   always_comb begin
`ifdef GATE_MAC_SAT_EN
      localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
         (ACC_WIDTH'(1) <<< (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
      localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
         -(ACC_WIDTH'(1) <<< (DATA_WIDTH - 1));
      if (acc_d > SAT_MAX) begin
         out_conv_s = SAT_MAX[DATA_WIDTH-1:0];
      end else if (acc_d < SAT_MIN) begin
         out_conv_s = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         out_conv_s = acc_d[DATA_WIDTH-1:0];
      end
`else
      out_conv_s = acc_d[DATA_WIDTH-1:0];
`endif
   end

   // The result register tracks the accumulator until DONE, then freezes.
   always_comb begin
      if (state_q != DONE) begin
         out_data_d = out_conv_s;
      end else begin
         out_data_d = out_data_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= {ACC_WIDTH{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         out_data_q  <= {DATA_WIDTH{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.term_cnt  = cnt_q;
endmodule
